mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: one read/write at a time against a word array,
// answered after a fixed wait-state latency with a one-cycle ack pulse.
module mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        fault
);

   localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] mem_q [DEPTH_WORDS];

   // Request registers, captured on the accept edge.
   logic          we_q;
   logic          flt_q;
   logic [AW-1:0] idx_q;
   logic [1:0]    off_q;
   logic [1:0]    size_q;
   logic [31:0]   wdata_q;

   logic [31:0] rdata_q;
   logic        ack_q;
   logic        busy_q;
   logic        fault_q;

   logic        accept_fault_d;
   logic [31:0] cur_word_d;
   logic [31:0] lane_data_d;
   logic [31:0] wr_word_d;
   logic [31:0] rd_data_d;
   logic [3:0]  be_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      accept_fault_d = 1'b0;
      case (size)
         2'b00:   accept_fault_d = 1'b0;
         2'b01:   accept_fault_d = addr[0];
         2'b10:   accept_fault_d = |addr[1:0];
         default: accept_fault_d = 1'b1;
      endcase
      if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) accept_fault_d = 1'b1;
   end

   // Big-endian lanes: byte offset 0 sits in bits [31:24].
   always_comb begin
      cur_word_d  = mem_q[idx_q];
      be_d        = 4'b1111;
      lane_data_d = wdata_q;
      rd_data_d   = cur_word_d;
      case (size_q)
         2'b00: begin
            be_d        = 4'b1000 >> off_q;
            lane_data_d = {4{wdata_q[7:0]}};
            rd_data_d   = {24'b0, 8'(cur_word_d >> {~off_q, 3'b000})};
         end
         2'b01: begin
            be_d        = off_q[1] ? 4'b0011 : 4'b1100;
            lane_data_d = {2{wdata_q[15:0]}};
            rd_data_d   = {16'b0, (off_q[1] ? cur_word_d[15:0] : cur_word_d[31:16])};
         end
         default: ;
      endcase
      wr_word_d = cur_word_d;
      for (int b = 0; b < 4; b++) begin
         if (be_d[b]) wr_word_d[8*b +: 8] = lane_data_d[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
         we_q    <= 1'b0;
         flt_q   <= 1'b0;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         // NOTE: the array is architecturally cleared by reset, so it is built from resettable flops.
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q   <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
               if (req) begin
                  state_q <= WAIT;
                  busy_q  <= 1'b1;
                  we_q    <= we;
                  flt_q   <= accept_fault_d;
                  idx_q   <= addr[AW+1:2];
                  off_q   <= addr[1:0];
                  size_q  <= size;
                  wdata_q <= wdata;
                  // A rejected request answers one edge after accept.
                  cnt_q   <= accept_fault_d ? 4'd0 : CNT_INIT;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
                  ack_q   <= 1'b1;
                  fault_q <= flt_q;
                  rdata_q <= '0;
                  if (!flt_q) begin
                     if (we_q) mem_q[idx_q] <= wr_word_d;
                     else      rdata_q      <= rd_data_d;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign busy  = busy_q;
   assign fault = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=3 and LATENCY=1 instances,
// byte-addressed reference memory and an expected-response queue.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req3, req1, we;
   logic [31:0] addr, wdata;
   logic [1:0]  size;
   logic [31:0] rdata3, rdata1;
   logic        ack3, ack1, busy3, busy1, fault3, fault1;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] ref_bytes [256];

   mem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .req(req3), .we(we), .addr(addr), .size(size),
      .wdata(wdata), .rdata(rdata3), .ack(ack3), .busy(busy3), .fault(fault3)
   );

   mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .size(size),
      .wdata(wdata), .rdata(rdata1), .ack(ack1), .busy(busy1), .fault(fault1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic o_ack(input bit sel);
      return sel ? ack1 : ack3;
   endfunction
   function automatic logic o_busy(input bit sel);
      return sel ? busy1 : busy3;
   endfunction
   function automatic logic o_fault(input bit sel);
      return sel ? fault1 : fault3;
   endfunction
   function automatic logic [31:0] o_rdata(input bit sel);
      return sel ? rdata1 : rdata3;
   endfunction

   // Byte-array model of the LATENCY=3 instance; address a holds the MSB lane.
   function automatic void model(input bit w, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic f);
      int n;
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      f  = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'd256);
      rd = '0;
      if (!f) begin
         for (int i = 0; i < n; i++) begin
            if (w) ref_bytes[8'(a + 32'(i))] = wd[8*(n-1-i) +: 8];
            else   rd = {rd[23:0], ref_bytes[8'(a + 32'(i))]};
         end
      end
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
   endtask

   // One complete access on the selected instance (0: LATENCY=3, 1: LATENCY=1).
   task automatic access(input bit sel, input bit w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input bit use_model, input logic [31:0] c_rd,
                         input bit c_f, input string name);
      exp_t        e, g;
      logic [31:0] m_rd;
      logic        m_f;
      int          n, busy_cnt, lat_exp;
      bit          got;
      if (!sel) model(w, a, sz, wd, m_rd, m_f);
      else begin
         m_rd = '0;
         m_f  = 1'b0;
      end
      e.rdata = use_model ? m_rd : c_rd;
      e.fault = use_model ? m_f  : c_f;
      lat_exp = (e.fault || sel) ? 1 : 3;
      sb.push_back(e);

      we = w; addr = a; size = sz; wdata = wd;
      if (sel) req1 = 1'b1; else req3 = 1'b1;
      @(posedge clk); #1;
      req1 = 1'b0; req3 = 1'b0;
      we = ~w; addr = ~a; size = ~sz; wdata = ~wd;
      busy_cnt = o_busy(sel) ? 1 : 0;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (o_busy(sel)) busy_cnt++;
         if (o_ack(sel)) got = 1'b1;
      end
      g = sb.pop_front();
      tests_run++;
      if (!got) begin
         tests_failed++;
         $display("FAIL %s timeout: no ack within %0d cycles", name, n);
      end else begin
         if (n !== lat_exp) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, n, lat_exp);
         end
         tests_run++;
         if (o_rdata(sel) !== g.rdata) begin
            tests_failed++;
            $display("FAIL %s rdata: got %h expected %h", name, o_rdata(sel), g.rdata);
         end
         tests_run++;
         if (o_fault(sel) !== g.fault) begin
            tests_failed++;
            $display("FAIL %s fault: got %b expected %b", name, o_fault(sel), g.fault);
         end
         tests_run++;
         if (busy_cnt !== lat_exp + 1) begin
            tests_failed++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, lat_exp + 1);
         end
      end
      @(posedge clk); #1;
      tests_run++;
      if ({o_ack(sel), o_busy(sel), o_fault(sel)} !== 3'b000) begin
         tests_failed++;
         $display("FAIL %s return to idle: ack/busy/fault = %b expected 000", name,
                  {o_ack(sel), o_busy(sel), o_fault(sel)});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req3 = 1'b0; req1 = 1'b0; we = 1'b0; addr = '0; size = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({rdata3, ack3, busy3, fault3} !== 35'd0 || {rdata1, ack1, busy1, fault1} !== 35'd0) begin
         tests_failed++;
         $display("FAIL reset outputs: dut3 %h/%b%b%b dut1 %h/%b%b%b expected all zero",
                  rdata3, ack3, busy3, fault3, rdata1, ack1, busy1, fault1);
      end
      reset = 1'b0;
      clear_model();
      access(0, 0, 32'h0000_0008, 2'd2, '0, 0, 32'h0000_0000, 0, "read_after_reset");
   endtask

   task automatic test_word_rw();
      access(0, 1, 32'h0000_0008, 2'd2, 32'hDEAD_BEEF, 0, 32'h0, 0, "word_write");
      access(0, 0, 32'h0000_0008, 2'd2, 32'h0,         0, 32'hDEAD_BEEF, 0, "word_read");
   endtask

   task automatic test_byte_half();
      access(0, 1, 32'h0000_0009, 2'd0, 32'h0000_0055, 0, 32'h0, 0, "byte_write");
      access(0, 0, 32'h0000_0008, 2'd2, 32'h0, 0, 32'hDE55_BEEF, 0, "word_after_byte");
      access(0, 0, 32'h0000_000B, 2'd0, 32'h0, 0, 32'h0000_00EF, 0, "byte_read_0b");
      access(0, 0, 32'h0000_000A, 2'd1, 32'h0, 0, 32'h0000_BEEF, 0, "half_read_0a");
      access(0, 1, 32'h0000_0020, 2'd1, 32'h0000_A1B2, 0, 32'h0, 0, "half_write_20");
      access(0, 0, 32'h0000_0020, 2'd2, 32'h0, 0, 32'hA1B2_0000, 0, "word_after_half");
   endtask

   task automatic test_faults();
      access(0, 0, 32'h0000_0003, 2'd1, 32'h0, 0, 32'h0, 1, "half_misaligned");
      access(0, 0, 32'h0000_0100, 2'd2, 32'h0, 0, 32'h0, 1, "word_out_of_range");
      access(0, 0, 32'h0000_0008, 2'd3, 32'h0, 0, 32'h0, 1, "size_reserved");
      access(0, 1, 32'h0000_0100, 2'd2, 32'hFFFF_FFFF, 0, 32'h0, 1, "write_oor");
      access(0, 1, 32'h0000_000A, 2'd2, 32'hFFFF_FFFF, 0, 32'h0, 1, "write_misaligned");
      access(0, 1, 32'h0000_0008, 2'd3, 32'hFFFF_FFFF, 0, 32'h0, 1, "write_reserved");
      access(0, 0, 32'h0000_0000, 2'd2, 32'h0, 0, 32'h0000_0000, 0, "word0_unchanged");
      access(0, 0, 32'h0000_0008, 2'd2, 32'h0, 0, 32'hDE55_BEEF, 0, "word8_unchanged");
   endtask

   task automatic test_req_ignored();
      exp_t e, g;
      int   acks, ack_at;
      model(0, 32'h0000_000B, 2'd0, '0, e.rdata, e.fault);
      sb.push_back(e);
      acks = 0; ack_at = 0;
      we = 1'b0; addr = 32'h0000_000B; size = 2'd0; wdata = '0;
      req3 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (ack3) begin
            acks++;
            ack_at = c;
            if (sb.size() != 0) begin
               g = sb.pop_front();
               tests_run++;
               if (rdata3 !== g.rdata) begin
                  tests_failed++;
                  $display("FAIL req_ignored rdata: got %h expected %h", rdata3, g.rdata);
               end
            end
         end
         req3 = (c == 2);
      end
      req3 = 1'b0;
      tests_run++;
      if (acks !== 1 || ack_at !== 4) begin
         tests_failed++;
         $display("FAIL req_ignored acks: got %0d (last at cycle %0d) expected 1 at cycle 4", acks, ack_at);
      end
      sb.delete();
   endtask

   task automatic test_back_to_back();
      exp_t e, g;
      int   acks[$];
      for (int i = 0; i < 4; i++) begin
         model(0, 32'h0000_0008, 2'd2, '0, e.rdata, e.fault);
         sb.push_back(e);
      end
      we = 1'b0; addr = 32'h0000_0008; size = 2'd2; wdata = '0;
      req3 = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         @(posedge clk); #1;
         if (ack3) begin
            acks.push_back(c);
            tests_run++;
            if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL back_to_back: unexpected ack at cycle %0d", c);
            end else begin
               g = sb.pop_front();
               if (rdata3 !== g.rdata || fault3 !== g.fault) begin
                  tests_failed++;
                  $display("FAIL back_to_back data: got %h/%b expected %h/%b", rdata3, fault3, g.rdata, g.fault);
               end
            end
         end
      end
      req3 = 1'b0;
      tests_run++;
      if (acks.size() != 4 || acks[0] != 4) begin
         tests_failed++;
         $display("FAIL back_to_back count: got %0d acks (first at %0d) expected 4 (first at 4)",
                  acks.size(), (acks.size() > 0) ? acks[0] : -1);
      end
      for (int i = 1; i < acks.size(); i++) begin
         tests_run++;
         if (acks[i] - acks[i-1] != 5) begin
            tests_failed++;
            $display("FAIL back_to_back spacing: got %0d expected 5", acks[i] - acks[i-1]);
         end
      end
      sb.delete();
      @(posedge clk); #1;
      tests_run++;
      if (busy3 !== 1'b0) begin
         tests_failed++;
         $display("FAIL back_to_back idle after release: busy=%b expected 0", busy3);
      end
   endtask

   task automatic test_reset_mid();
      access(0, 0, 32'h0000_0008, 2'd2, '0, 1, '0, 0, "read_before_abort");
      we = 1'b1; addr = 32'h0000_0010; size = 2'd2; wdata = 32'h1234_5678;
      req3 = 1'b1;
      @(posedge clk); #1;
      req3 = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (busy3 !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort busy before reset: got %b expected 1", busy3);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({rdata3, ack3, busy3, fault3} !== 35'd0) begin
         tests_failed++;
         $display("FAIL abort outputs: got %h/%b%b%b expected all zero", rdata3, ack3, busy3, fault3);
      end
      reset = 1'b0;
      clear_model();
      access(0, 0, 32'h0000_0010, 2'd2, '0, 0, 32'h0000_0000, 0, "aborted_write");
      access(0, 0, 32'h0000_0008, 2'd2, '0, 0, 32'h0000_0000, 0, "cleared_by_reset");
   endtask

   task automatic test_latency1();
      access(1, 1, 32'h0000_0004, 2'd2, 32'hCAFE_F00D, 0, 32'h0, 0, "l1_write");
      access(1, 0, 32'h0000_0004, 2'd2, 32'h0, 0, 32'hCAFE_F00D, 0, "l1_read");
      access(1, 0, 32'h0000_0006, 2'd1, 32'h0, 0, 32'h0000_F00D, 0, "l1_half");
      access(1, 0, 32'h0000_0101, 2'd0, 32'h0, 0, 32'h0, 1, "l1_fault");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [1:0]  sz;
      int          n;
      for (int i = 0; i < 16; i++) begin
         sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         a  = 32'($urandom_range(0, 263));
         if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
         access(0, 1'($urandom_range(0, 1)), a, sz, $urandom, 1, '0, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_half();
      test_faults();
      test_req_ignored();
      test_back_to_back();
      test_reset_mid();
      test_latency1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
